// File: rtl/sopc_reg_bank_if.sv
// Avalon-MM register slave bus for sopc_reg_bank.
interface sopc_reg_bank_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0]   avs_reg_address;
    logic                avs_reg_read_n;
    logic                avs_reg_write_n;
    logic [DATA_W-1:0]   avs_reg_writedata;
    logic [DATA_W/8-1:0] avs_reg_byteenable;
    logic [DATA_W-1:0]   avs_reg_readdata;
    logic                avs_reg_readdatavalid;
    logic                avs_reg_waitrequest_n;

    modport master (
        output avs_reg_address,
        output avs_reg_read_n,
        output avs_reg_write_n,
        output avs_reg_writedata,
        output avs_reg_byteenable,
        input  avs_reg_readdata,
        input  avs_reg_readdatavalid,
        input  avs_reg_waitrequest_n
    );

    modport slave (
        input  avs_reg_address,
        input  avs_reg_read_n,
        input  avs_reg_write_n,
        input  avs_reg_writedata,
        input  avs_reg_byteenable,
        output avs_reg_readdata,
        output avs_reg_readdatavalid,
        output avs_reg_waitrequest_n
    );
endinterface

// File: rtl/sopc_reg_bank.sv
// Parametrised Avalon-MM register bank: RW, read-only status and W1C event
// registers, byte enables, pipelined reads and an event interrupt.
module sopc_reg_bank #(
    parameter int          DATA_W       = 32,
    parameter int          NUM_REGS     = 8,
    parameter int          ADDR_W       = 3,
    parameter int          READ_LATENCY = 1,
    parameter logic [15:0] RO_MASK      = '0,
    parameter logic [15:0] W1C_MASK     = '0
) (
    input  logic                         csi_clockreset_clk,
    input  logic                         csi_clockreset_reset_n,
    sopc_reg_bank_if.slave               avs_reg,
    output logic [NUM_REGS*DATA_W-1:0]   coe_reg_q,
    input  logic [NUM_REGS*DATA_W-1:0]   coe_status_in,
    output logic                         coe_irq
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {S_WAIT0, S_WAIT1, S_READY} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_ready;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_irq;
    logic              w_unused_status;
    logic [DATA_W-1:0] w_be_mask;
    logic [DATA_W-1:0] w_rd_mux;
    logic [DATA_W-1:0] r_regs     [NUM_REGS];
    logic [DATA_W-1:0] w_regs_nxt [NUM_REGS];
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;

    // Start-up state register: counts the two edges after reset release.
    always_ff @(posedge csi_clockreset_clk or negedge csi_clockreset_reset_n) begin
        if (!csi_clockreset_reset_n) begin
            r_state <= S_WAIT0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Start-up next state; the bus is opened only once S_READY is reached.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            S_WAIT0: w_state_nxt = S_WAIT1;
            S_WAIT1: w_state_nxt = S_READY;
            S_READY: w_ready     = 1'b1;
            default: w_state_nxt = S_WAIT0;
        endcase
    end

    assign avs_reg.avs_reg_waitrequest_n = w_ready;

    // A simultaneous read and write performs only the write.
    assign w_wr_acc = w_ready & ~avs_reg.avs_reg_write_n;
    assign w_rd_acc = w_ready & ~avs_reg.avs_reg_read_n & avs_reg.avs_reg_write_n;

    // Status slices of plain RW registers are intentionally ignored.
    assign w_unused_status = ^coe_status_in;

    // Expand byte enables to a bit mask.
    always_comb begin
        w_be_mask = '0;
        for (int unsigned b = 0; b < BE_W; b++) begin
            w_be_mask[b*8 +: 8] = {8{avs_reg.avs_reg_byteenable[b]}};
        end
    end

    // Read mux on pre-update register values; unmapped addresses read 0.
    always_comb begin
        w_rd_mux = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (avs_reg.avs_reg_address == ADDR_W'(i)) begin
                w_rd_mux = r_regs[i];
            end
        end
    end

    // Per-register next value according to its RW / RO / W1C personality.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            w_regs_nxt[i] = r_regs[i];
            if (W1C_MASK[i]) begin
                // Clear first, then OR in new events so that set wins.
                if (w_wr_acc && avs_reg.avs_reg_address == ADDR_W'(i)) begin
                    w_regs_nxt[i] = r_regs[i] & ~(avs_reg.avs_reg_writedata & w_be_mask);
                end
                w_regs_nxt[i] = w_regs_nxt[i] | coe_status_in[i*DATA_W +: DATA_W];
            end else if (RO_MASK[i]) begin
                w_regs_nxt[i] = coe_status_in[i*DATA_W +: DATA_W];
            end else if (w_wr_acc && avs_reg.avs_reg_address == ADDR_W'(i)) begin
                w_regs_nxt[i] = (r_regs[i] & ~w_be_mask)
                              | (avs_reg.avs_reg_writedata & w_be_mask);
            end
        end
    end

    // Register storage.
    always_ff @(posedge csi_clockreset_clk or negedge csi_clockreset_reset_n) begin
        if (!csi_clockreset_reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_regs <= w_regs_nxt;
        end
    end

    // Flatten registers onto the conduit and OR all event bits into the irq.
    always_comb begin
        coe_reg_q = '0;
        w_irq     = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            coe_reg_q[i*DATA_W +: DATA_W] = r_regs[i];
            if (W1C_MASK[i]) begin
                w_irq = w_irq | (|r_regs[i]);
            end
        end
    end

    assign coe_irq = w_irq;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic              r_s1_vld;
            logic [DATA_W-1:0] r_s1_data;

            // Two-stage read pipeline; readdata only moves with a valid beat.
            always_ff @(posedge csi_clockreset_clk or negedge csi_clockreset_reset_n) begin
                if (!csi_clockreset_reset_n) begin
                    r_s1_vld  <= 1'b0;
                    r_s1_data <= '0;
                    r_rvalid  <= 1'b0;
                    r_rdata   <= '0;
                end else begin
                    r_s1_vld <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_s1_data <= w_rd_mux;
                    end
                    r_rvalid <= r_s1_vld;
                    if (r_s1_vld) begin
                        r_rdata <= r_s1_data;
                    end
                end
            end
        end else begin : g_lat1
            // Single-stage read response; readdata holds between reads.
            always_ff @(posedge csi_clockreset_clk or negedge csi_clockreset_reset_n) begin
                if (!csi_clockreset_reset_n) begin
                    r_rvalid <= 1'b0;
                    r_rdata  <= '0;
                end else begin
                    r_rvalid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rdata <= w_rd_mux;
                    end
                end
            end
        end
    endgenerate

    assign avs_reg.avs_reg_readdata      = r_rdata;
    assign avs_reg.avs_reg_readdatavalid = r_rvalid;
endmodule

// File: tb/tb_sopc_reg_bank.sv
// Directed bench for sopc_reg_bank: one latency-1 and one latency-2 instance
// driven by the same bus stimulus.
module tb_sopc_reg_bank;
    localparam int DW = 32;
    localparam int NR = 8;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0]    addr;
    logic             rd_n;
    logic             wr_n;
    logic [DW-1:0]    wdata;
    logic [DW/8-1:0]  be;
    logic [NR*DW-1:0] status;
    logic [NR*DW-1:0] q1;
    logic [NR*DW-1:0] q2;
    logic             irq1;
    logic             irq2;

    int n_checks = 0;
    int n_err    = 0;

    logic [AW-1:0] pa [5];
    logic [DW-1:0] pe [5];

    sopc_reg_bank_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
    sopc_reg_bank_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

    assign bus1.avs_reg_address    = addr;
    assign bus1.avs_reg_read_n     = rd_n;
    assign bus1.avs_reg_write_n    = wr_n;
    assign bus1.avs_reg_writedata  = wdata;
    assign bus1.avs_reg_byteenable = be;
    assign bus2.avs_reg_address    = addr;
    assign bus2.avs_reg_read_n     = rd_n;
    assign bus2.avs_reg_write_n    = wr_n;
    assign bus2.avs_reg_writedata  = wdata;
    assign bus2.avs_reg_byteenable = be;

    sopc_reg_bank #(
        .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .READ_LATENCY(1),
        .RO_MASK(16'h0008), .W1C_MASK(16'h0004)
    ) dut1 (
        .csi_clockreset_clk     (clk),
        .csi_clockreset_reset_n (rst_n),
        .avs_reg                (bus1.slave),
        .coe_reg_q              (q1),
        .coe_status_in          (status),
        .coe_irq                (irq1)
    );

    sopc_reg_bank #(
        .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .READ_LATENCY(2),
        .RO_MASK(16'h0008), .W1C_MASK(16'h0004)
    ) dut2 (
        .csi_clockreset_clk     (clk),
        .csi_clockreset_reset_n (rst_n),
        .avs_reg                (bus2.slave),
        .coe_reg_q              (q2),
        .coe_status_in          (status),
        .coe_irq                (irq2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rq(input logic [NR*DW-1:0] q, input int i);
        return q[i*DW +: DW];
    endfunction

    task automatic check_reset_state(input string tag);
        chkb({tag, "_wrq1"}, bus1.avs_reg_waitrequest_n, 1'b0);
        chkb({tag, "_wrq2"}, bus2.avs_reg_waitrequest_n, 1'b0);
        chkb({tag, "_rdv1"}, bus1.avs_reg_readdatavalid, 1'b0);
        chkb({tag, "_rdv2"}, bus2.avs_reg_readdatavalid, 1'b0);
        chk ({tag, "_rdd1"}, bus1.avs_reg_readdata, 32'h0);
        chk ({tag, "_rdd2"}, bus2.avs_reg_readdata, 32'h0);
        chkb({tag, "_irq1"}, irq1, 1'b0);
        chkb({tag, "_irq2"}, irq2, 1'b0);
        chkb({tag, "_q1"}, (q1 == '0), 1'b1);
        chkb({tag, "_q2"}, (q2 == '0), 1'b1);
    endtask

    initial begin
        addr   = '0;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        wdata  = '0;
        be     = '0;
        status = '0;
        pa = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd9};
        pe = '{32'h12345678, 32'h11BB33DD, 32'h00000008, 32'hCAFEF00D, 32'h00000000};

        // Reset state
        tick();
        tick();
        check_reset_state("reset");

        // Release reset with a write already pending; it must be held off
        rst_n = 1'b1;
        addr  = 4'd0;
        wdata = 32'hDEADBEEF;
        be    = 4'hF;
        wr_n  = 1'b0;
        tick();
        chkb("wrq_edge1_dut1", bus1.avs_reg_waitrequest_n, 1'b0);
        chkb("wrq_edge1_dut2", bus2.avs_reg_waitrequest_n, 1'b0);
        tick();
        chkb("wrq_edge2_dut1", bus1.avs_reg_waitrequest_n, 1'b1);
        chkb("wrq_edge2_dut2", bus2.avs_reg_waitrequest_n, 1'b1);
        chk ("stalled_write_reg0", rq(q1, 0), 32'h0);
        wr_n = 1'b1;
        tick();
        chk ("stalled_write_reg0_later", rq(q1, 0), 32'h0);

        // Byte enables on RW register 1
        addr  = 4'd1;
        wdata = 32'h11223344;
        be    = 4'hF;
        wr_n  = 1'b0;
        tick();
        wdata = 32'hAABBCCDD;
        be    = 4'h5;
        tick();
        wr_n = 1'b1;
        chk("be_reg1_dut1", rq(q1, 1), 32'h11BB33DD);
        chk("be_reg1_dut2", rq(q2, 1), 32'h11BB33DD);
        rd_n = 1'b0;
        tick();
        rd_n = 1'b1;
        chkb("lat_rdv1_c1", bus1.avs_reg_readdatavalid, 1'b1);
        chk ("lat_rdd1_c1", bus1.avs_reg_readdata, 32'h11BB33DD);
        chkb("lat_rdv2_c1", bus2.avs_reg_readdatavalid, 1'b0);
        tick();
        chkb("lat_rdv1_c2", bus1.avs_reg_readdatavalid, 1'b0);
        chk ("lat_rdd1_hold", bus1.avs_reg_readdata, 32'h11BB33DD);
        chkb("lat_rdv2_c2", bus2.avs_reg_readdatavalid, 1'b1);
        chk ("lat_rdd2_c2", bus2.avs_reg_readdata, 32'h11BB33DD);
        tick();
        chkb("lat_rdv2_c3", bus2.avs_reg_readdatavalid, 1'b0);

        // W1C register 2
        status[2*DW+3] = 1'b1;
        tick();
        status[2*DW+3] = 1'b0;
        chk ("w1c_set_reg2", rq(q1, 2), 32'h8);
        chkb("w1c_set_irq", irq1, 1'b1);
        tick();
        chk ("w1c_sticky_reg2", rq(q1, 2), 32'h8);
        addr  = 4'd2;
        wdata = 32'h8;
        be    = 4'hF;
        wr_n  = 1'b0;
        tick();
        wr_n = 1'b1;
        chk ("w1c_clr_reg2", rq(q1, 2), 32'h0);
        chkb("w1c_clr_irq", irq1, 1'b0);
        status[2*DW+3] = 1'b1;
        wr_n = 1'b0;
        tick();
        wr_n = 1'b1;
        status[2*DW+3] = 1'b0;
        chk ("w1c_set_wins", rq(q1, 2), 32'h8);
        chkb("w1c_set_wins_irq", irq1, 1'b1);
        wdata = 32'h0;
        wr_n  = 1'b0;
        tick();
        wr_n = 1'b1;
        chk ("w1c_write0", rq(q1, 2), 32'h8);
        wdata = 32'h8;
        be    = 4'h0;
        wr_n  = 1'b0;
        tick();
        wr_n = 1'b1;
        be   = 4'hF;
        chk ("w1c_lane_off", rq(q1, 2), 32'h8);

        // RO register 3
        status[3*DW +: DW] = 32'h5A5A5A5A;
        tick();
        chk("ro_sample", rq(q1, 3), 32'h5A5A5A5A);
        addr  = 4'd3;
        wdata = 32'h0;
        wr_n  = 1'b0;
        tick();
        wr_n = 1'b1;
        chk("ro_write_ignored", rq(q1, 3), 32'h5A5A5A5A);
        rd_n = 1'b0;
        tick();
        rd_n = 1'b1;
        chkb("ro_rdv1", bus1.avs_reg_readdatavalid, 1'b1);
        chk ("ro_rdd1", bus1.avs_reg_readdata, 32'h5A5A5A5A);
        status[3*DW +: DW] = 32'h1;
        tick();
        tick();
        rd_n = 1'b0;
        tick();
        rd_n = 1'b1;
        chk ("ro_new_rdd1", bus1.avs_reg_readdata, 32'h1);
        tick();
        chkb("ro_new_rdv2", bus2.avs_reg_readdatavalid, 1'b1);
        chk ("ro_new_rdd2", bus2.avs_reg_readdata, 32'h1);

        // Pipelined reads of 0,1,2,7 and unmapped address 9
        addr  = 4'd0;
        wdata = 32'h12345678;
        wr_n  = 1'b0;
        tick();
        addr  = 4'd7;
        wdata = 32'hCAFEF00D;
        tick();
        wr_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            addr = pa[k];
            rd_n = 1'b0;
            tick();
            chkb($sformatf("pipe_rdv1_%0d", k), bus1.avs_reg_readdatavalid, 1'b1);
            chk ($sformatf("pipe_rdd1_%0d", k), bus1.avs_reg_readdata, pe[k]);
            if (k > 0) begin
                chkb($sformatf("pipe_rdv2_%0d", k), bus2.avs_reg_readdatavalid, 1'b1);
                chk ($sformatf("pipe_rdd2_%0d", k), bus2.avs_reg_readdata, pe[k-1]);
            end else begin
                chkb("pipe_rdv2_first", bus2.avs_reg_readdatavalid, 1'b0);
            end
        end
        rd_n = 1'b1;
        tick();
        chkb("pipe_rdv1_end", bus1.avs_reg_readdatavalid, 1'b0);
        chkb("pipe_rdv2_last", bus2.avs_reg_readdatavalid, 1'b1);
        chk ("pipe_rdd2_last", bus2.avs_reg_readdata, pe[4]);
        tick();
        chkb("pipe_rdv2_end", bus2.avs_reg_readdatavalid, 1'b0);

        // Simultaneous read and write: only the write happens
        addr  = 4'd0;
        wdata = 32'h0BADF00D;
        wr_n  = 1'b0;
        rd_n  = 1'b0;
        tick();
        wr_n = 1'b1;
        rd_n = 1'b1;
        chk ("rw_write_done", rq(q1, 0), 32'h0BADF00D);
        chkb("rw_no_rdv1", bus1.avs_reg_readdatavalid, 1'b0);
        tick();
        chkb("rw_no_rdv2", bus2.avs_reg_readdatavalid, 1'b0);

        // Reset with reads in flight
        chkb("pre_reset_irq", irq1, 1'b1);
        addr = 4'd1;
        rd_n = 1'b0;
        tick();
        addr = 4'd7;
        chkb("inflight_rdv1", bus1.avs_reg_readdatavalid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        rd_n = 1'b1;
        check_reset_state("midreset");
        tick();
        tick();
        chkb("flush_rdv1", bus1.avs_reg_readdatavalid, 1'b0);
        chkb("flush_rdv2", bus2.avs_reg_readdatavalid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/sopc_reg_bank.md
# sopc_reg_bank

Parametrised Avalon-MM slave register bank, the successor to the single 8-bit test register. It provides NUM_REGS registers of DATA_W bits, each independently configured as read/write, read-only status or write-1-to-clear event. It adds byte enables, a pipelined read path with readdatavalid, and an interrupt output. It sits on the SOPC system interconnect as the general control/status block for custom peripherals.

## Interface
Parameters:
- DATA_W, 32: register width; multiple of 8, range 8..32.
- NUM_REGS, 8: number of registers, range 2..16.
- ADDR_W, 3: word address width; must satisfy 2^ADDR_W >= NUM_REGS.
- READ_LATENCY, 1: cycles from read command to readdatavalid; legal values 1 or 2.
- RO_MASK, 0: bit i = 1 makes register i read-only status.
- W1C_MASK, 0: bit i = 1 makes register i a write-1-to-clear event register. Takes precedence over RO_MASK.

Ports:
- csi_clockreset_clk  in  1  sole clock, rising edge.
- csi_clockreset_reset_n  in  1  reset, asynchronous assert, active-low.
- avs_reg_address  in  ADDR_W  word address.
- avs_reg_read_n  in  1  read strobe, active-low.
- avs_reg_write_n  in  1  write strobe, active-low.
- avs_reg_writedata  in  DATA_W  write data.
- avs_reg_byteenable  in  DATA_W/8  byte lane enables, active-high.
- avs_reg_readdata  out  DATA_W  read data, valid when readdatavalid = 1.
- avs_reg_readdatavalid  out  1  read data qualifier.
- avs_reg_waitrequest_n  out  1  0 stalls the master.
- coe_reg_q  out  NUM_REGS*DATA_W  contents of all registers, register i at bits [i*DATA_W +: DATA_W].
- coe_status_in  in  NUM_REGS*DATA_W  status and event inputs, same packing.
- coe_irq  out  1  OR of all W1C register bits.

## Operation
- A command is accepted in a cycle where waitrequest_n = 1 and a strobe is low.
- Reset: all registers = 0, readdata = 0, readdatavalid = 0, waitrequest_n = 0, irq = 0.
- waitrequest_n rises on the second clock edge after reset deassertion and then stays 1. Commands presented while it is 0 are held off and have no effect.
- RW register: on a write, each byte lane with byteenable = 1 takes writedata. Disabled lanes keep their value.
- RO register:
  - Each clock, the register is loaded with its coe_status_in slice (one-cycle sample).
  - Writes are ignored.
- W1C register, per bit:
  - Set when its coe_status_in bit is 1 in that cycle.
  - Cleared by a write of 1 in an enabled lane.
  - If set and clear occur in the same cycle, set wins.
  - Writing 0 has no effect.
- Address >= NUM_REGS: a write is ignored; a read returns 0 with readdatavalid asserted.
- read_n and write_n both low in the same cycle: the write is performed, the read is dropped, and no readdatavalid is produced.
- Read data is the register value before any update in the command cycle.
- irq = OR of all W1C bits, taken combinationally from the flops; no extra latency.

## Timing
- Read issued at edge N: readdata and readdatavalid = 1 are presented after edge N+READ_LATENCY, for exactly one cycle per read.
- Back-to-back reads, one per cycle, are fully pipelined; responses return in order with no bubbles.
- readdata holds its last value while readdatavalid = 0.
- Write: the new value is visible on coe_reg_q after the accepting edge. A read issued in the next cycle returns the new value.
- W1C set: status bit high in cycle N; the register bit and irq are 1 after edge N.
- RO sample: coe_status_in in cycle N appears in the register after edge N.
- Reset mid-read: the pipeline is flushed. No readdatavalid is produced for in-flight reads.

## Test plan
- Reset release: waitrequest_n stays 0 for 1 edge and is 1 after the 2nd. A write of 0xDEADBEEF to reg 0 issued during the stall leaves reg 0 = 0.
- Byte enables, RW reg 1: write 0x11223344 with be = 1111, then 0xAABBCCDD with be = 0101. Reading reg 1 returns 0x11BB33DD, with readdatavalid exactly READ_LATENCY cycles after the read (check both latency 1 and 2).
- W1C, W1C_MASK = 0x04:
  - Pulse status bit 3 of reg 2 for 1 cycle: reg 2 = 0x8 and irq = 1.
  - Write 0x8: reg 2 = 0 and irq = 0.
  - Repeat the clear write while the status bit is held high: the bit stays 1.
- RO reg 3 with status = 0x5A5A5A5A: a write of 0 is ignored and a read returns 0x5A5A5A5A. Change status to 0x1: a read issued 2 cycles later returns 0x1.
- Pipelined reads of regs 0,1,2,7 then address 9 (with NUM_REGS = 8, ADDR_W = 4) on consecutive cycles: 5 consecutive readdatavalid pulses, in order, the last returning 0.
- Read and write to reg 0 in the same cycle: the write takes effect and no readdatavalid is produced. Assert reset with 2 reads in flight: no readdatavalid and all outputs return to their reset values.
